// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//
// Data-memory slave for the MEMORY stage load/store port. It serves one
// word-sized LW/SW at a time with byte strobes and returns the response a
// fixed LATENCY cycles after the request handshake.
//
// Parameters
//   DEPTH_WORDS : number of 32-bit words of storage (power of two, >= 2)
//   LATENCY     : request-handshake edge to resp_valid, in cycles (>= 1)
//
// Ports
//   clk, resetn                 : rising-edge clock, async active-low reset
//   req_valid / req_ready       : request channel handshake
//   req_write                   : 1 = store, 0 = load
//   req_addr, req_wdata         : byte address, store data
//   req_strobe                  : byte enables for stores
//   resp_valid / resp_ready     : response channel handshake
//   resp_rdata, resp_err        : load data (0 for stores/errors), error flag
//
// FSM states
//   state  | meaning
//   -------+---------------------------------------------------------
//   IDLE   | ready for a request; access performed on the handshake
//   WAIT   | latency counter running down toward the response
//   RESP   | response presented, held until resp_valid & resp_ready
// ---------------------------------------------------------------------------
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_strobe,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    // Counter only has to hold LATENCY-1.
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [CW-1:0]   cnt_q;
    logic [31:0]     mem [DEPTH_WORDS];

    logic            req_hs;
    logic            resp_hs;
    logic            addr_err;
    logic [AW-1:0]   word_idx;

    assign req_hs   = req_valid & req_ready;
    assign resp_hs  = resp_valid & resp_ready;
    assign word_idx = req_addr[AW+1:2];
    assign addr_err = (req_addr[1:0] != 2'b00) ||
                      (req_addr[31:2] >= 30'(DEPTH_WORDS));

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req_hs) begin
                    state_d = (LATENCY == 1) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == CW'(1)) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_hs) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode: req_ready depends on the state register only.
    always_comb begin
        req_ready = 1'b0;
        if (state_q == S_IDLE) begin
            req_ready = 1'b1;
        end
    end

    // Latency counter and registered response.
    // The load is read at the handshake edge, so the captured word already
    // reflects every store whose handshake came earlier.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q      <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            if (req_hs) begin
                cnt_q      <= CW'(LATENCY - 1);
                resp_err   <= addr_err;
                resp_rdata <= (!addr_err && !req_write) ? mem[word_idx] : '0;
            end else if (state_q == S_WAIT) begin
                cnt_q <= cnt_q - CW'(1);
            end
            resp_valid <= (state_d == S_RESP);
        end
    end

    // Storage is deliberately outside the reset domain so contents survive
    // resetn, including a store committed just before a mid-flight reset.
    always_ff @(posedge clk) begin
        if (req_hs && req_write && !addr_err) begin
            for (int b = 0; b < 4; b++) begin
                if (req_strobe[b]) begin
                    mem[word_idx][8*b +: 8] <= req_wdata[8*b +: 8];
                end
            end
        end
    end

endmodule
